mig_port_emu: RTL and testbench
===============================

# mig_port_emu

Synthesizable responder for one MIG (MCB-style) user port: accepts commands, write data and read-data pops exactly as the DDR3 controller port does, and serves them from an on-chip word memory. It sits where the MIG core would be, behind `nkmd_ddr3` or any other port master. Its uses are DDR-less bring-up and closed-loop simulation of the port masters. Command, write-data and read-data FIFOs and their status flags follow the MIG port contract.

## Interface
Parameters:
- `AW`, 10 — memory word-address width (2^AW × 32-bit words)
- `FIFO_DEPTH`, 64 — write- and read-data FIFO depth (power of two, ≤64)
- `RD_LAT`, 4 — cycles from read-command pop to first read-data push (≥1)

Ports (`mig_*` directions are from this block):
- `clk` in 1 — sole clock
- `rst` in 1 — synchronous, active-low reset
- `mig_cmd_en` in 1 — push command
- `mig_cmd_instr` in 3 — 000 write, 001 read, 010 write+AP, 011 read+AP, 100 refresh, others no-op
- `mig_cmd_bl` in 6 — burst length minus one (1..64 words)
- `mig_cmd_byte_addr` in 30 — byte address; bits [1:0] ignored
- `mig_cmd_empty` out 1, `mig_cmd_full` out 1 — command FIFO status
- `mig_wr_en` in 1, `mig_wr_data` in 32, `mig_wr_mask` in 4 — push write word; mask bit 1 = byte NOT written
- `mig_wr_full` out 1, `mig_wr_empty` out 1, `mig_wr_count` out 7 — write FIFO status/occupancy
- `mig_wr_underrun` out 1, `mig_wr_error` out 1 — write faults
- `mig_rd_en` in 1 — pop read word
- `mig_rd_data` out 32 — read FIFO head (first-word-fall-through)
- `mig_rd_full` out 1, `mig_rd_empty` out 1, `mig_rd_count` out 7 — read FIFO status/occupancy
- `mig_rd_overflow` out 1, `mig_rd_error` out 1 — read faults

## Operation
- Command FIFO, depth 4. A `cmd_en` while full is dropped.
- Engine FSM: IDLE → (pop cmd) → WRITE | READ_WAIT | IDLE (refresh/no-op, 1 cycle).
- WRITE: one beat per cycle, BL+1 beats, then IDLE. Each beat pops the write FIFO and writes memory word `(byte_addr[AW+1:2] + beat) mod 2^AW`, so bursts wrap within memory.
- Write FIFO empty when a beat is due: `mig_wr_underrun` = 1 that cycle, word 32'h0 written, burst continues.
- READ_WAIT: counts RD_LAT−1 cycles → READ.
- READ: one word per cycle pushed to the read FIFO, BL+1 words, same address rule, then IDLE.
- Push while read FIFO full (and no same-cycle pop): word dropped, `mig_rd_overflow` = 1 that cycle.
- `wr_en` while write FIFO full: word dropped, `mig_wr_error` set.
- `mig_wr_error` is sticky and also set by any underrun. `mig_rd_error` is sticky and set by any overflow. Both clear only on reset.
- Pop on an empty read FIFO is ignored and is not an error.
- `mig_rd_data` is undefined while `mig_rd_empty` = 1.
- Memory contents are not cleared by reset.

## Timing
- Reset (rst = 0 at a clk edge):
  - all FIFOs empty, FSM IDLE
  - `cmd_empty` = `wr_empty` = `rd_empty` = 1
  - `*_full` = 0, counts = 0
  - underrun/overflow/error = 0, `mig_rd_data` = 0
- Reset mid-burst aborts the burst. Queued commands and FIFO data are discarded.
- All status outputs are registered and reflect pushes/pops of the previous edge.
- Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- Command pop: the edge after `cmd_empty` = 0 in IDLE. The first write beat or latency count starts the next cycle.
- Read latency: the first word is visible (`rd_empty` = 0) RD_LAT+1 cycles after the `cmd_en` edge on an idle engine.
- Back-to-back commands: the next pop occurs in the cycle after the last beat. There are no bubbles beyond the 1-cycle IDLE.
- A write beat and a `wr_en` in the same cycle on an empty FIFO count as underrun. There is no bypass.

## Configuration
- `MIG_PORT_EMU_BYTE_MASK_EN` defined: `mig_wr_mask` is stored per word, and masked bytes retain their old memory value.
- Not defined: the mask is ignored, every beat writes all 4 bytes, and no mask storage is built.

## Structure
- Package `mig_port_emu_pkg`: instruction codes (`MIG_INSTR_WR`, `_RD`, `_WRAP`, `_RDAP`, `_REF`), FSM state enum (IDLE, WRITE, READ_WAIT, READ), command struct {instr, bl, word addr}.
- Sub-module `mig_emu_fifo` (parameterized width/depth; full, empty, count, FWFT head) is instantiated three times.
- Memory and FSM are in the top module.

## Test plan
- Push 8 words 1..8, then cmd write `byte_addr` 0x200, BL=7; then cmd read same address, BL=7 → `rd_count` reaches 8, pops return 1..8 in order; `wr_empty` = 1.
- Read 1 word at 0x000 on an idle engine → `rd_empty` falls exactly RD_LAT+1 cycles after `cmd_en`.
- Write cmd BL=3 with only 2 words queued → `wr_underrun` pulses 2 cycles, `wr_error` stays 1; read-back gives w0, w1, 0, 0.
- Read BL=63 twice without popping (FIFO_DEPTH = 64) → `rd_full` = 1 after 64 words, `rd_overflow` pulses 64 times, `rd_error` sticky.
- Write 2 words at word 2^AW−1 → second word lands at word 0 (wrap).
- With `MIG_PORT_EMU_BYTE_MASK_EN`: write 0x11223344, then 0xAABBCCDD with mask 4'b0101 → read 0xAA22CC44. Without the macro → 0xAABBCCDD.

Source files
------------

// File: rtl/mig_port_emu_pkg.sv
// mig_port_emu_pkg
// Shared definitions for the MIG user-port emulator: command instruction
// codes, the engine state encoding, the queued command record and a couple
// of instruction-decode helpers.
// No ports (package).
package mig_port_emu_pkg;

    localparam logic [2:0] MIG_INSTR_WR   = 3'b000;
    localparam logic [2:0] MIG_INSTR_RD   = 3'b001;
    localparam logic [2:0] MIG_INSTR_WRAP = 3'b010;
    localparam logic [2:0] MIG_INSTR_RDAP = 3'b011;
    localparam logic [2:0] MIG_INSTR_REF  = 3'b100;

    localparam int CMD_FIFO_DEPTH = 4;
    // Occupancy counters are sized for the largest supported FIFO (64)
    localparam int COUNT_W        = 7;
    // Word address as carried by the port (byte address bits [29:2])
    localparam int CMD_ADDR_W     = 28;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ
    } engineState_t;

    typedef struct packed {
        logic [2:0]            instr;
        logic [5:0]            bl;
        logic [CMD_ADDR_W-1:0] waddr;
    } migCmd_t;

    function automatic logic isWriteInstr(input logic [2:0] instr);
        return (instr == MIG_INSTR_WR) || (instr == MIG_INSTR_WRAP);
    endfunction

    function automatic logic isReadInstr(input logic [2:0] instr);
        return (instr == MIG_INSTR_RD) || (instr == MIG_INSTR_RDAP);
    endfunction

endpackage

// File: rtl/mig_emu_fifo.sv
// mig_emu_fifo
// Synchronous first-word-fall-through FIFO with registered full/empty/count.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored. The head reads as zero while empty.
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   i_push, i_data push strobe and word
//   i_pop          pop strobe
//   o_head         current head word (FWFT)
//   o_full/o_empty registered status flags
//   o_count        registered occupancy
module mig_emu_fifo
    import mig_port_emu_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [W-1:0]       i_data,
    input  logic               i_pop,
    output logic [W-1:0]       o_head,
    output logic               o_full,
    output logic               o_empty,
    output logic [COUNT_W-1:0] o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]       r_store [DEPTH];
    logic [PW-1:0]      r_wrPtr;
    logic [PW-1:0]      r_rdPtr;
    logic [COUNT_W-1:0] r_count;
    logic               r_full;
    logic               r_empty;

    logic               w_doPush;
    logic               w_doPop;
    logic [COUNT_W-1:0] w_nextCount;

    assign w_doPop  = i_pop && !r_empty;
    assign w_doPush = i_push && (!r_full || w_doPop);

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_nextCount = r_count;
        if (w_doPush && !w_doPop) begin
            w_nextCount = r_count + COUNT_W'(1);
        end else if (!w_doPush && w_doPop) begin
            w_nextCount = r_count - COUNT_W'(1);
        end
    end

    // Pointers and flags; flags are derived from the next count so they are
    // registered yet always consistent with the occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= w_nextCount;
            r_full  <= (w_nextCount == COUNT_W'(DEPTH));
            r_empty <= (w_nextCount == '0);
        end
    end

    // Storage is not reset; the pointers alone define validity
    always_ff @(posedge clk) begin
        if (rst && w_doPush) begin
            r_store[r_wrPtr] <= i_data;
        end
    end

    assign o_head  = r_empty ? '0 : r_store[r_rdPtr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/mig_port_emu.sv
// mig_port_emu
// Stand-in for one MIG (MCB-style) user port. Commands, write words and
// read pops are taken exactly as the DDR3 controller would take them and are
// served from an on-chip array of 2^AW 32-bit words.
// Optional feature macro: MIG_PORT_EMU_BYTE_MASK_EN -- when defined the write
// mask is stored with each word and masked bytes keep their old value; when
// undefined the mask is ignored and every beat writes the full word.
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   mig_cmd_*                        command push, instr/bl/byte address, status
//   mig_wr_en/data/mask              write-data push
//   mig_wr_full/empty/count          write FIFO status
//   mig_wr_underrun, mig_wr_error    write faults (error sticky)
//   mig_rd_en, mig_rd_data           read pop and FWFT head
//   mig_rd_full/empty/count          read FIFO status
//   mig_rd_overflow, mig_rd_error    read faults (error sticky)
module mig_port_emu
    import mig_port_emu_pkg::*;
#(
    parameter int AW         = 10,
    parameter int FIFO_DEPTH = 64,
    parameter int RD_LAT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mig_cmd_en,
    input  logic [2:0]  mig_cmd_instr,
    input  logic [5:0]  mig_cmd_bl,
    input  logic [29:0] mig_cmd_byte_addr,
    output logic        mig_cmd_empty,
    output logic        mig_cmd_full,
    input  logic        mig_wr_en,
    input  logic [31:0] mig_wr_data,
    input  logic [3:0]  mig_wr_mask,
    output logic        mig_wr_full,
    output logic        mig_wr_empty,
    output logic [6:0]  mig_wr_count,
    output logic        mig_wr_underrun,
    output logic        mig_wr_error,
    input  logic        mig_rd_en,
    output logic [31:0] mig_rd_data,
    output logic        mig_rd_full,
    output logic        mig_rd_empty,
    output logic [6:0]  mig_rd_count,
    output logic        mig_rd_overflow,
    output logic        mig_rd_error
);

    localparam int          CMD_W    = $bits(migCmd_t);
    localparam logic [15:0] LAT_INIT = (RD_LAT >= 2) ? 16'(RD_LAT - 2) : 16'd0;
`ifdef MIG_PORT_EMU_BYTE_MASK_EN
    localparam int          WR_W     = 36;
`else
    localparam int          WR_W     = 32;
`endif

    engineState_t  r_state;
    logic [AW-1:0] r_addr;
    logic [5:0]    r_remain;
    logic [15:0]   r_latCnt;
    logic          r_wrUnderrun;
    logic          r_rdOverflow;
    logic          r_wrError;
    logic          r_rdError;

    logic [31:0]   r_mem [2**AW];

    migCmd_t       w_cmdIn;
    migCmd_t       w_cmdHead;
    logic [6:0]    w_cmdCount;
    logic          w_cmdPop;
    logic [WR_W-1:0] w_wrIn;
    logic [WR_W-1:0] w_wrHead;
    logic          w_wrBeat;
    logic          w_rdPush;
    logic [31:0]   w_rdWord;
    logic          w_wrUnderrunEv;
    logic          w_wrDropEv;
    logic          w_rdOverflowEv;

    assign w_cmdIn = '{instr: mig_cmd_instr, bl: mig_cmd_bl, waddr: mig_cmd_byte_addr[29:2]};

`ifdef MIG_PORT_EMU_BYTE_MASK_EN
    assign w_wrIn = {mig_wr_mask, mig_wr_data};
`else
    assign w_wrIn = mig_wr_data;
`endif

    assign w_cmdPop = (r_state == IDLE) && (w_cmdCount != '0);
    assign w_wrBeat = (r_state == WRITE);
    assign w_rdPush = (r_state == READ);
    assign w_rdWord = r_mem[r_addr];

    mig_emu_fifo #(.W(CMD_W), .DEPTH(CMD_FIFO_DEPTH)) u_cmdFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (mig_cmd_en),
        .i_data  (w_cmdIn),
        .i_pop   (w_cmdPop),
        .o_head  (w_cmdHead),
        .o_full  (mig_cmd_full),
        .o_empty (mig_cmd_empty),
        .o_count (w_cmdCount)
    );

    // A write beat pops the write FIFO even when empty; the pop is then
    // ignored and the zero head is what gets written
    mig_emu_fifo #(.W(WR_W), .DEPTH(FIFO_DEPTH)) u_wrFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (mig_wr_en),
        .i_data  (w_wrIn),
        .i_pop   (w_wrBeat),
        .o_head  (w_wrHead),
        .o_full  (mig_wr_full),
        .o_empty (mig_wr_empty),
        .o_count (mig_wr_count)
    );

    mig_emu_fifo #(.W(32), .DEPTH(FIFO_DEPTH)) u_rdFifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rdPush),
        .i_data  (w_rdWord),
        .i_pop   (mig_rd_en),
        .o_head  (mig_rd_data),
        .o_full  (mig_rd_full),
        .o_empty (mig_rd_empty),
        .o_count (mig_rd_count)
    );

    // Command engine: pop in IDLE, then one beat per cycle until the burst
    // is done. r_addr walks the burst and wraps naturally at 2^AW words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_latCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmdPop) begin
                        r_addr   <= w_cmdHead.waddr[AW-1:0];
                        r_remain <= w_cmdHead.bl;
                        r_latCnt <= LAT_INIT;
                        if (isWriteInstr(w_cmdHead.instr)) begin
                            r_state <= WRITE;
                        end else if (isReadInstr(w_cmdHead.instr)) begin
                            // With RD_LAT of 1 there is no wait cycle at all
                            r_state <= (RD_LAT <= 1) ? READ : READ_WAIT;
                        end
                    end
                end
                WRITE, READ: begin
                    r_addr <= r_addr + AW'(1);
                    if (r_remain == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_remain <= r_remain - 6'd1;
                    end
                end
                READ_WAIT: begin
                    if (r_latCnt == '0) begin
                        r_state <= READ;
                    end else begin
                        r_latCnt <= r_latCnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Word memory, deliberately left out of reset
    always_ff @(posedge clk) begin
        if (rst && w_wrBeat) begin
`ifdef MIG_PORT_EMU_BYTE_MASK_EN
            for (int b = 0; b < 4; b++) begin
                if (!w_wrHead[32+b]) begin
                    r_mem[r_addr][8*b +: 8] <= w_wrHead[8*b +: 8];
                end
            end
`else
            r_mem[r_addr] <= w_wrHead;
`endif
        end
    end

    assign w_wrUnderrunEv = w_wrBeat && mig_wr_empty;
    // When full the FIFO is non-empty, so a beat that cycle frees a slot
    assign w_wrDropEv     = mig_wr_en && mig_wr_full && !w_wrBeat;
    assign w_rdOverflowEv = w_rdPush && mig_rd_full && !mig_rd_en;

    // Fault flags: pulses for the event cycle, sticky errors until reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrUnderrun <= 1'b0;
            r_rdOverflow <= 1'b0;
            r_wrError    <= 1'b0;
            r_rdError    <= 1'b0;
        end else begin
            r_wrUnderrun <= w_wrUnderrunEv;
            r_rdOverflow <= w_rdOverflowEv;
            r_wrError    <= r_wrError | w_wrUnderrunEv | w_wrDropEv;
            r_rdError    <= r_rdError | w_rdOverflowEv;
        end
    end

    assign mig_wr_underrun = r_wrUnderrun;
    assign mig_wr_error    = r_wrError;
    assign mig_rd_overflow = r_rdOverflow;
    assign mig_rd_error    = r_rdError;

endmodule

// File: tb/tb_mig_port_emu.sv
`timescale 1ns/1ps
// tb_mig_port_emu
// Drives the emulated MIG port with directed and randomized bursts and
// compares everything against a word-level model of memory and FIFOs.
module tb_mig_port_emu;
    import mig_port_emu_pkg::*;

    localparam int AW         = 10;
    localparam int FIFO_DEPTH = 64;
    localparam int RD_LAT     = 4;
    localparam int MEM_WORDS  = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mig_cmd_en = 1'b0;
    logic [2:0]  mig_cmd_instr = '0;
    logic [5:0]  mig_cmd_bl = '0;
    logic [29:0] mig_cmd_byte_addr = '0;
    logic        mig_cmd_empty, mig_cmd_full;
    logic        mig_wr_en = 1'b0;
    logic [31:0] mig_wr_data = '0;
    logic [3:0]  mig_wr_mask = '0;
    logic        mig_wr_full, mig_wr_empty;
    logic [6:0]  mig_wr_count;
    logic        mig_wr_underrun, mig_wr_error;
    logic        mig_rd_en = 1'b0;
    logic [31:0] mig_rd_data;
    logic        mig_rd_full, mig_rd_empty;
    logic [6:0]  mig_rd_count;
    logic        mig_rd_overflow, mig_rd_error;

    mig_port_emu #(.AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .mig_cmd_en(mig_cmd_en), .mig_cmd_instr(mig_cmd_instr), .mig_cmd_bl(mig_cmd_bl),
        .mig_cmd_byte_addr(mig_cmd_byte_addr), .mig_cmd_empty(mig_cmd_empty), .mig_cmd_full(mig_cmd_full),
        .mig_wr_en(mig_wr_en), .mig_wr_data(mig_wr_data), .mig_wr_mask(mig_wr_mask),
        .mig_wr_full(mig_wr_full), .mig_wr_empty(mig_wr_empty), .mig_wr_count(mig_wr_count),
        .mig_wr_underrun(mig_wr_underrun), .mig_wr_error(mig_wr_error),
        .mig_rd_en(mig_rd_en), .mig_rd_data(mig_rd_data), .mig_rd_full(mig_rd_full),
        .mig_rd_empty(mig_rd_empty), .mig_rd_count(mig_rd_count),
        .mig_rd_overflow(mig_rd_overflow), .mig_rd_error(mig_rd_error)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;
    int expUnderruns = 0;

    logic [31:0] modelMem [MEM_WORDS];
    logic [31:0] wrQData [$];
    logic [3:0]  wrQMask [$];
    logic [31:0] expQ [$];

    // Byte-merge rule of the port: mask bit 1 keeps the old byte
    function automatic logic [31:0] mergeWord(input logic [31:0] oldW, input logic [31:0] newW, input logic [3:0] mask);
        logic [31:0] res;
        res = newW;
`ifdef MIG_PORT_EMU_BYTE_MASK_EN
        for (int b = 0; b < 4; b++) if (mask[b]) res[8*b +: 8] = oldW[8*b +: 8];
`endif
        return res;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushWord(input logic [31:0] d, input logic [3:0] m);
        mig_wr_en = 1'b1; mig_wr_data = d; mig_wr_mask = m;
        wrQData.push_back(d); wrQMask.push_back(m);
        tick();
        mig_wr_en = 1'b0;
    endtask

    // Issue one command and advance the model by the whole command
    task automatic sendCmd(input logic [2:0] instr, input int bl, input int wordAddr);
        int a;
        logic [31:0] d;
        logic [3:0] m;
        mig_cmd_en = 1'b1; mig_cmd_instr = instr; mig_cmd_bl = 6'(bl);
        mig_cmd_byte_addr = {28'(wordAddr), 2'($urandom_range(0, 3))};
        tick();
        mig_cmd_en = 1'b0;
        for (int b = 0; b <= bl; b++) begin
            a = (wordAddr + b) % MEM_WORDS;
            if (instr == MIG_INSTR_WR || instr == MIG_INSTR_WRAP) begin
                if (wrQData.size() == 0) begin
                    modelMem[a] = 32'h0;
                    expUnderruns++;
                end else begin
                    d = wrQData.pop_front(); m = wrQMask.pop_front();
                    modelMem[a] = mergeWord(modelMem[a], d, m);
                end
            end else if (instr == MIG_INSTR_RD || instr == MIG_INSTR_RDAP) begin
                expQ.push_back(modelMem[a]);
            end
        end
    endtask

    task automatic popWord(output logic [31:0] d);
        d = mig_rd_data;
        mig_rd_en = 1'b1;
        tick();
        mig_rd_en = 1'b0;
    endtask

    task automatic waitRdCount(input int target, input int bound, output bit reached);
        int c;
        c = 0;
        while (int'(mig_rd_count) < target && c < bound) begin tick(); c++; end
        reached = (int'(mig_rd_count) >= target);
    endtask

    task automatic test_reset(input string tag);
        mig_cmd_en = 1'b0; mig_wr_en = 1'b0; mig_rd_en = 1'b0;
        rst = 1'b0;
        tick(2);
        wrQData.delete(); wrQMask.delete(); expQ.delete();
        nChecks++; if (mig_cmd_empty !== 1'b1) $display("[TB] FAIL %s cmd_empty: got %b expected 1", tag, mig_cmd_empty); else nPass++;
        nChecks++; if (mig_cmd_full !== 1'b0) $display("[TB] FAIL %s cmd_full: got %b expected 0", tag, mig_cmd_full); else nPass++;
        nChecks++; if (mig_wr_empty !== 1'b1) $display("[TB] FAIL %s wr_empty: got %b expected 1", tag, mig_wr_empty); else nPass++;
        nChecks++; if (mig_wr_full !== 1'b0) $display("[TB] FAIL %s wr_full: got %b expected 0", tag, mig_wr_full); else nPass++;
        nChecks++; if (mig_wr_count !== 7'd0) $display("[TB] FAIL %s wr_count: got %0d expected 0", tag, mig_wr_count); else nPass++;
        nChecks++; if (mig_rd_empty !== 1'b1) $display("[TB] FAIL %s rd_empty: got %b expected 1", tag, mig_rd_empty); else nPass++;
        nChecks++; if (mig_rd_full !== 1'b0) $display("[TB] FAIL %s rd_full: got %b expected 0", tag, mig_rd_full); else nPass++;
        nChecks++; if (mig_rd_count !== 7'd0) $display("[TB] FAIL %s rd_count: got %0d expected 0", tag, mig_rd_count); else nPass++;
        nChecks++; if (mig_wr_underrun !== 1'b0) $display("[TB] FAIL %s wr_underrun: got %b expected 0", tag, mig_wr_underrun); else nPass++;
        nChecks++; if (mig_rd_overflow !== 1'b0) $display("[TB] FAIL %s rd_overflow: got %b expected 0", tag, mig_rd_overflow); else nPass++;
        nChecks++; if (mig_wr_error !== 1'b0) $display("[TB] FAIL %s wr_error: got %b expected 0", tag, mig_wr_error); else nPass++;
        nChecks++; if (mig_rd_error !== 1'b0) $display("[TB] FAIL %s rd_error: got %b expected 0", tag, mig_rd_error); else nPass++;
        nChecks++; if (mig_rd_data !== 32'h0) $display("[TB] FAIL %s rd_data: got %h expected 0", tag, mig_rd_data); else nPass++;
        rst = 1'b1;
        tick();
    endtask

    // Eight words 1..8 written at byte 0x200 and read straight back
    task automatic test_basic();
        bit reached;
        logic [31:0] got, exp;
        for (int i = 1; i <= 8; i++) pushWord(32'(i), 4'h0);
        nChecks++; if (mig_wr_count !== 7'd8) $display("[TB] FAIL basic_wr_count: got %0d expected 8", mig_wr_count); else nPass++;
        sendCmd(MIG_INSTR_WR, 7, 32'h200 >> 2);
        sendCmd(MIG_INSTR_RD, 7, 32'h200 >> 2);
        waitRdCount(8, 100, reached);
        nChecks++; if (!reached) $display("[TB] FAIL basic_timeout: rd_count %0d, required 8", mig_rd_count); else nPass++;
        nChecks++; if (mig_rd_count !== 7'd8) $display("[TB] FAIL basic_rd_count: got %0d expected 8", mig_rd_count); else nPass++;
        nChecks++; if (mig_wr_empty !== 1'b1) $display("[TB] FAIL basic_wr_empty: got %b expected 1", mig_wr_empty); else nPass++;
        for (int i = 0; i < 8; i++) begin
            popWord(got); exp = expQ.pop_front();
            nChecks++; if (got !== exp) $display("[TB] FAIL basic_data[%0d]: got %h expected %h", i, got, exp); else nPass++;
        end
        tick();
        nChecks++; if (mig_rd_empty !== 1'b1) $display("[TB] FAIL basic_rd_empty: got %b expected 1", mig_rd_empty); else nPass++;
    endtask

    // Two words at the last memory word: the second lands at word 0
    task automatic test_wrap();
        bit reached;
        logic [31:0] got, exp;
        pushWord($urandom, 4'h0);
        pushWord($urandom, 4'h0);
        sendCmd(MIG_INSTR_WR, 1, MEM_WORDS - 1);
        sendCmd(MIG_INSTR_RD, 1, MEM_WORDS - 1);
        sendCmd(MIG_INSTR_RD, 0, 0);
        waitRdCount(3, 100, reached);
        nChecks++; if (!reached) $display("[TB] FAIL wrap_timeout: rd_count %0d, required 3", mig_rd_count); else nPass++;
        for (int i = 0; i < 3; i++) begin
            popWord(got); exp = expQ.pop_front();
            nChecks++; if (got !== exp) $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, got, exp); else nPass++;
        end
        tick(2);
    endtask

    task automatic test_latency();
        int cycles;
        logic [31:0] got, exp;
        sendCmd(MIG_INSTR_RD, 0, 0);
        cycles = 0;
        while (mig_rd_empty && cycles < 50) begin tick(); cycles++; end
        nChecks++; if (cycles != RD_LAT + 1) $display("[TB] FAIL read_latency: got %0d cycles expected %0d", cycles, RD_LAT + 1); else nPass++;
        popWord(got); exp = expQ.pop_front();
        nChecks++; if (got !== exp) $display("[TB] FAIL latency_data: got %h expected %h", got, exp); else nPass++;
        tick(2);
    endtask

    // BL=3 write with only two words queued
    task automatic test_underrun();
        int pulses;
        bit reached;
        logic [31:0] got, exp;
        nChecks++; if (mig_wr_error !== 1'b0) $display("[TB] FAIL underrun_pre_error: got %b expected 0", mig_wr_error); else nPass++;
        expUnderruns = 0;
        pushWord($urandom, 4'h0);
        pushWord($urandom, 4'h0);
        sendCmd(MIG_INSTR_WRAP, 3, 800);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (mig_wr_underrun) pulses++;
            tick();
        end
        nChecks++; if (pulses != expUnderruns) $display("[TB] FAIL underrun_pulses: got %0d expected %0d", pulses, expUnderruns); else nPass++;
        nChecks++; if (mig_wr_error !== 1'b1) $display("[TB] FAIL underrun_error: got %b expected 1", mig_wr_error); else nPass++;
        sendCmd(MIG_INSTR_RD, 3, 800);
        waitRdCount(4, 100, reached);
        nChecks++; if (!reached) $display("[TB] FAIL underrun_timeout: rd_count %0d, required 4", mig_rd_count); else nPass++;
        for (int i = 0; i < 4; i++) begin
            popWord(got); exp = expQ.pop_front();
            nChecks++; if (got !== exp) $display("[TB] FAIL underrun_data[%0d]: got %h expected %h", i, got, exp); else nPass++;
        end
        nChecks++; if (mig_wr_error !== 1'b1) $display("[TB] FAIL underrun_sticky: got %b expected 1", mig_wr_error); else nPass++;
        tick(2);
    endtask

    task automatic test_mask();
        bit reached;
        logic [31:0] got, exp, fixed;
`ifdef MIG_PORT_EMU_BYTE_MASK_EN
        fixed = 32'hAA22CC44;
`else
        fixed = 32'hAABBCCDD;
`endif
        pushWord(32'h11223344, 4'b0000);
        sendCmd(MIG_INSTR_WR, 0, 700);
        pushWord(32'hAABBCCDD, 4'b0101);
        sendCmd(MIG_INSTR_WR, 0, 700);
        sendCmd(MIG_INSTR_RD, 0, 700);
        waitRdCount(1, 100, reached);
        nChecks++; if (!reached) $display("[TB] FAIL mask_timeout: rd_count %0d, required 1", mig_rd_count); else nPass++;
        popWord(got); exp = expQ.pop_front();
        nChecks++; if (got !== exp) $display("[TB] FAIL mask_model: got %h expected %h", got, exp); else nPass++;
        nChecks++; if (got !== fixed) $display("[TB] FAIL mask_value: got %h expected %h", got, fixed); else nPass++;
        tick(2);
    endtask

    // Random bursts, each write immediately followed by its read-back,
    // sometimes with a refresh or no-op wedged in between
    task automatic test_back_to_back();
        bit reached;
        int wa, bl, sel;
        logic [31:0] got, exp;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) pushWord($urandom, 4'h0);
            nChecks++; if (mig_wr_full !== 1'b1) $display("[TB] FAIL prefill_wr_full[%0d]: got %b expected 1", k, mig_wr_full); else nPass++;
            sendCmd(MIG_INSTR_WR, 63, 256 + 64 * k);
            tick(70);
            nChecks++; if (mig_wr_empty !== 1'b1) $display("[TB] FAIL prefill_wr_empty[%0d]: got %b expected 1", k, mig_wr_empty); else nPass++;
        end
        for (int it = 0; it < 12; it++) begin
            wa = 256 + $urandom_range(0, 240);
            bl = $urandom_range(0, 15);
            for (int i = 0; i <= bl; i++) pushWord($urandom, 4'($urandom_range(0, 15)));
            nChecks++; if (int'(mig_wr_count) != bl + 1) $display("[TB] FAIL b2b_wr_count[%0d]: got %0d expected %0d", it, mig_wr_count, bl + 1); else nPass++;
            sendCmd($urandom_range(0, 1) ? MIG_INSTR_WR : MIG_INSTR_WRAP, bl, wa);
            sel = $urandom_range(0, 2);
            if (sel == 1) sendCmd(MIG_INSTR_REF, $urandom_range(0, 63), $urandom_range(0, MEM_WORDS - 1));
            if (sel == 2) sendCmd(3'($urandom_range(5, 7)), $urandom_range(0, 63), $urandom_range(0, MEM_WORDS - 1));
            sendCmd($urandom_range(0, 1) ? MIG_INSTR_RD : MIG_INSTR_RDAP, bl, wa);
            waitRdCount(bl + 1, 200, reached);
            nChecks++; if (!reached) $display("[TB] FAIL b2b_timeout[%0d]: rd_count %0d, required %0d", it, mig_rd_count, bl + 1); else nPass++;
            for (int i = 0; i <= bl; i++) begin
                popWord(got); exp = expQ.pop_front();
                nChecks++; if (got !== exp) $display("[TB] FAIL b2b_data[%0d][%0d]: got %h expected %h", it, i, got, exp); else nPass++;
            end
        end
        tick(2);
    endtask

    // Two BL=63 reads with nobody popping: the second burst overflows entirely
    task automatic test_overflow();
        int pulses;
        logic [31:0] got, exp;
        bit reached;
        sendCmd(MIG_INSTR_RD, 63, 0);
        sendCmd(MIG_INSTR_RD, 63, 0);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            if (mig_rd_overflow) pulses++;
            tick();
        end
        nChecks++; if (pulses != 64) $display("[TB] FAIL overflow_pulses: got %0d expected 64", pulses); else nPass++;
        nChecks++; if (mig_rd_full !== 1'b1) $display("[TB] FAIL overflow_rd_full: got %b expected 1", mig_rd_full); else nPass++;
        nChecks++; if (mig_rd_count !== 7'd64) $display("[TB] FAIL overflow_rd_count: got %0d expected 64", mig_rd_count); else nPass++;
        nChecks++; if (mig_rd_error !== 1'b1) $display("[TB] FAIL overflow_rd_error: got %b expected 1", mig_rd_error); else nPass++;
        popWord(got);
        nChecks++; if (mig_rd_count !== 7'd63) $display("[TB] FAIL overflow_pop_count: got %0d expected 63", mig_rd_count); else nPass++;
        nChecks++; if (mig_rd_full !== 1'b0) $display("[TB] FAIL overflow_pop_full: got %b expected 0", mig_rd_full); else nPass++;
        nChecks++; if (mig_rd_error !== 1'b1) $display("[TB] FAIL overflow_sticky: got %b expected 1", mig_rd_error); else nPass++;
        // Start a write burst, then reset in the middle of it
        for (int i = 0; i < 16; i++) pushWord($urandom, 4'h0);
        sendCmd(MIG_INSTR_WR, 15, 600);
        tick(5);
        test_reset("midburst_reset");
        sendCmd(MIG_INSTR_RD, 7, 32'h200 >> 2);
        waitRdCount(8, 100, reached);
        nChecks++; if (!reached) $display("[TB] FAIL post_reset_timeout: rd_count %0d, required 8", mig_rd_count); else nPass++;
        tick(3);
        nChecks++; if (mig_rd_count !== 7'd8) $display("[TB] FAIL post_reset_rd_count: got %0d expected 8", mig_rd_count); else nPass++;
        for (int i = 0; i < 8; i++) begin
            popWord(got); exp = expQ.pop_front();
            nChecks++; if (got !== exp) $display("[TB] FAIL post_reset_data[%0d]: got %h expected %h", i, got, exp); else nPass++;
        end
    endtask

    initial begin
        test_reset("reset");
        test_basic();
        test_wrap();
        test_latency();
        test_underrun();
        test_mask();
        test_back_to_back();
        test_overflow();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d so far", nPass, nChecks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
